// File: rtl/immediate_generator_pipe_pkg.sv
// ---------------------------------------------------------------------------
// immediate_generator_pipe_pkg
// Purpose : shared select codes and default widths for the pipelined
//           immediate generator and its format-extraction sub-module.
// Contents: imm_sel_e   - 3-bit immediate format select codes
//           IMM_XLEN_DEFAULT, IMM_TAG_W_DEFAULT - default parameter values
// ---------------------------------------------------------------------------
package immediate_generator_pipe_pkg;

  localparam int IMM_XLEN_DEFAULT  = 32;
  localparam int IMM_TAG_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    IMM_ITYPE = 3'b000,
    IMM_STYPE = 3'b001,
    IMM_BTYPE = 3'b010,
    IMM_UTYPE = 3'b011,
    IMM_JTYPE = 3'b100,
    IMM_RTYPE = 3'b101,  // shift amount
    IMM_ZTYPE = 3'b110,  // CSR unsigned immediate
    IMM_RSVD  = 3'b111   // reserved: decoded as ITYPE, flagged illegal
  } imm_sel_e;

endpackage

// File: rtl/immediate_generator_pipe_imm_extract.sv
// ---------------------------------------------------------------------------
// imm_extract
// Purpose : combinational immediate decode and sign/zero extension.
// Ports   : i_immsel  [2:0]      format select (imm_sel_e)
//           i_data    [31:0]     instruction word
//           o_imm     [XLEN-1:0] extended immediate
//           o_illegal            select code was the reserved value
// ---------------------------------------------------------------------------
module imm_extract
  import immediate_generator_pipe_pkg::*;
#(
  parameter int XLEN = IMM_XLEN_DEFAULT
) (
  input  logic [2:0]      i_immsel,
  input  logic [31:0]     i_data,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  // Every format fits in 32 bits; it is built here first and widened once.
  logic [31:0] w_imm32;
  logic        w_sext;
  logic        w_unused;

  // The opcode field never contributes to an immediate.
  assign w_unused = &{1'b0, i_data[6:0]};

  always_comb begin
    w_imm32   = {{20{i_data[31]}}, i_data[31:20]};
    w_sext    = 1'b1;
    o_illegal = 1'b0;
    case (imm_sel_e'(i_immsel))
      IMM_STYPE: w_imm32 = {{20{i_data[31]}}, i_data[31:25], i_data[11:7]};
      IMM_BTYPE: w_imm32 = {{20{i_data[31]}}, i_data[7], i_data[30:25],
                            i_data[11:8], 1'b0};
      IMM_UTYPE: w_imm32 = {i_data[31:12], 12'b0};
      IMM_JTYPE: w_imm32 = {{12{i_data[31]}}, i_data[19:12], i_data[20],
                            i_data[30:21], 1'b0};
      IMM_RTYPE: begin
        w_sext  = 1'b0;
        // 64-bit shifts need the sixth shamt bit.
        w_imm32 = (XLEN == 64) ? {26'b0, i_data[25:20]} : {27'b0, i_data[24:20]};
      end
      IMM_ZTYPE: begin
        w_sext  = 1'b0;
        w_imm32 = {27'b0, i_data[19:15]};
      end
      IMM_RSVD:  o_illegal = 1'b1;
      default:   ;  // ITYPE uses the defaults above
    endcase
  end

  // UTYPE on XLEN=64 gets bits 63:32 from the sign through this same path.
  assign o_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);

endmodule

// File: rtl/immediate_generator_pipe.sv
// ---------------------------------------------------------------------------
// immediate_generator_pipe
// Purpose : registered immediate generator with a valid/ready handshake and
//           a 2-entry skid buffer (slot 0 drives outputs, slot 1 absorbs
//           one extra result so O_ready can be registered).
// Ports   : I_clk, I_rst_n (async, active-low)
//           I_valid/O_ready, I_immsel, I_data, I_tag   - request side
//           O_valid/I_ready, O_data, O_tag, O_illegal  - result side
// ---------------------------------------------------------------------------
module immediate_generator_pipe
  import immediate_generator_pipe_pkg::*;
#(
  parameter int XLEN  = IMM_XLEN_DEFAULT,
  parameter int TAG_W = IMM_TAG_W_DEFAULT
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [2:0]       I_immsel,
  input  logic [31:0]      I_data,
  input  logic [TAG_W-1:0] I_tag,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [XLEN-1:0]  O_data,
  output logic [TAG_W-1:0] O_tag,
  output logic             O_illegal
);

  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .i_immsel (I_immsel),
    .i_data   (I_data),
    .o_imm    (w_imm),
    .o_illegal(w_illegal)
  );

  logic             r_v0, r_v1, r_ready;
  logic [XLEN-1:0]  r_data0, r_data1;
  logic [TAG_W-1:0] r_tag0, r_tag1;
  logic             r_ill0, r_ill1;

  logic w_accept, w_drain, w_load1, w_hold1;

  assign w_accept = I_valid & r_ready;
  assign w_drain  = r_v0 & I_ready;
  // New result parks in slot 1 only when slot 0 is occupied and stays so.
  assign w_load1  = w_accept & r_v0 & ~w_drain;
  assign w_hold1  = r_v1 & ~w_drain;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_ready <= 1'b0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_tag0  <= '0;
      r_tag1  <= '0;
      r_ill0  <= 1'b0;
      r_ill1  <= 1'b0;
    end else begin
      if (w_drain && r_v1) begin
        // Skid entry is older than anything arriving, so it goes first.
        r_data0 <= r_data1;
        r_tag0  <= r_tag1;
        r_ill0  <= r_ill1;
        r_v1    <= 1'b0;
      end else if (w_accept && (!r_v0 || w_drain)) begin
        r_data0 <= w_imm;
        r_tag0  <= I_tag;
        r_ill0  <= w_illegal;
        r_v0    <= 1'b1;
      end else if (w_drain) begin
        r_v0    <= 1'b0;
      end

      if (w_load1) begin
        r_data1 <= w_imm;
        r_tag1  <= I_tag;
        r_ill1  <= w_illegal;
        r_v1    <= 1'b1;
      end

      // Ready mirrors next-cycle emptiness of slot 1, so it never sees I_ready
      // combinationally and comes back one edge after reset release.
      r_ready <= ~(w_load1 | w_hold1);
    end
  end

  assign O_ready   = r_ready;
  assign O_valid   = r_v0;
  assign O_data    = r_data0;
  assign O_tag     = r_tag0;
  assign O_illegal = r_ill0;

endmodule

// File: tb/tb_immediate_generator_pipe.sv
// ---------------------------------------------------------------------------
// tb_immediate_generator_pipe
// Drives one XLEN=32 and one XLEN=64 instance with identical stimulus.
// A queue model predicts occupancy, ready and payload; directed phases pin
// literal results, backpressure, reserved select and async reset.
// ---------------------------------------------------------------------------
module tb_immediate_generator_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [2:0]  i_sel = 3'd0;
  logic [31:0] i_data = 32'd0;
  logic [4:0]  i_tag = 5'd0;

  logic        o_ready32, o_valid32, ill32;
  logic [31:0] d32;
  logic [4:0]  tag32;
  logic        o_ready64, o_valid64, ill64;
  logic [63:0] d64;
  logic [4:0]  tag64;

  always #5 clk = ~clk;

  immediate_generator_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(i_valid), .O_ready(o_ready32),
    .I_immsel(i_sel), .I_data(i_data), .I_tag(i_tag), .O_valid(o_valid32),
    .I_ready(i_ready), .O_data(d32), .O_tag(tag32), .O_illegal(ill32)
  );

  immediate_generator_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(i_valid), .O_ready(o_ready64),
    .I_immsel(i_sel), .I_data(i_data), .I_tag(i_tag), .O_valid(o_valid64),
    .I_ready(i_ready), .O_data(d64), .O_tag(tag64), .O_illegal(ill64)
  );

  typedef struct {
    logic [31:0] d32;
    logic [63:0] d64;
    logic [4:0]  tag;
    logic        ill;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  res_t q[$];
  res_t log_q[$];
  bit   armed = 1'b0;
  int   n_push = 0;
  int   n_xfer = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s bound expired @%0t", name, $time);
  endtask

  // Immediate value by plain arithmetic on the field widths.
  function automatic logic [63:0] model_imm(input logic [2:0] sel, input logic [31:0] w,
                                            input bit is64);
    longint v;
    case (sel)
      3'd1: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 64'sd4096; end
      3'd2: begin
        v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
        if (w[31]) v -= 64'sd8192;
      end
      3'd3: begin v = longint'(w[31:12]) * 64'sd4096; if (w[31]) v -= 64'sh1_0000_0000; end
      3'd4: begin
        v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0});
        if (w[31]) v -= 64'sd2097152;
      end
      3'd5: v = is64 ? longint'(w[25:20]) : longint'(w[24:20]);
      3'd6: v = longint'(w[19:15]);
      default: begin v = longint'(w[31:20]); if (w[31]) v -= 64'sd4096; end
    endcase
    return 64'(v);
  endfunction

  // Model update and transfer log, on the same edge the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      armed = 1'b0;
    end else begin
      bit          do_pop, do_push;
      res_t        e;
      logic [63:0] t;
      do_pop  = (q.size() > 0) && i_ready;
      do_push = i_valid && armed && (q.size() < 2);
      if (o_valid32 && i_ready) begin
        e.d32 = d32; e.d64 = d64; e.tag = tag32; e.ill = ill32;
        log_q.push_back(e);
        n_xfer++;
        $display("[TB] xfer tag=%0d d32=%h d64=%h ill=%0b", tag32, d32, d64, ill32);
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        t = model_imm(i_sel, i_data, 1'b0);
        e.d32 = t[31:0];
        e.d64 = model_imm(i_sel, i_data, 1'b1);
        e.tag = i_tag;
        e.ill = (i_sel == 3'b111);
        q.push_back(e);
        n_push++;
      end
      armed = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      bit   ev, er;
      res_t e;
      ev = (q.size() > 0);
      er = armed && (q.size() < 2);
      check("valid32", o_valid32, ev);
      check("valid64", o_valid64, ev);
      check("ready32", o_ready32, er);
      check("ready64", o_ready64, er);
      if (ev && o_valid32 && o_valid64) begin
        e = q[0];
        check("data32", d32, e.d32);
        check("data64", d64, e.d64);
        check("tag32", tag32, e.tag);
        check("tag64", tag64, e.tag);
        check("ill32", ill32, e.ill);
        check("ill64", ill64, e.ill);
      end
    end
  end

  task automatic send(input logic [2:0] s, input logic [31:0] w, input logic [4:0] t);
    bit r;
    int n;
    i_valid = 1'b1; i_sel = s; i_data = w; i_tag = t;
    n = 0;
    do begin
      @(negedge clk); r = o_ready32;
      @(posedge clk); #1; n++;
    end while (!r && n < 50);
    if (!r) timeout("send");
  endtask

  localparam int ND = 10;
  logic [2:0]  dir_sel  [ND] = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd6, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2};
  logic [31:0] dir_word [ND] = '{32'hFFF00093, 32'hFE20AE23, 32'hFFDFF06F, 32'h123450B7,
                                 32'h000FD073, 32'h80000037, 32'h03F09093, 32'h00500093,
                                 32'h00500093, 32'hFE000EE3};
  logic [31:0] dir_e32  [ND] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000,
                                 32'h0000001F, 32'h80000000, 32'h0000001F, 32'h00000005,
                                 32'h00000005, 32'hFFFFFFFC};
  logic [63:0] dir_e64  [ND] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                                 64'h000000000000001F, 64'hFFFFFFFF80000000,
                                 64'h000000000000003F, 64'h0000000000000005,
                                 64'h0000000000000005, 64'hFFFFFFFFFFFFFFFC};
  logic        dir_ill  [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int base, n, sent, cyc, p0, x0;
    bit acc;
    localparam int NR = 10000;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_valid32, 1'b0);
    check("rst_ready", o_ready32, 1'b0);
    check("rst_data", d64, 64'd0);
    check("rst_tag", tag32, 5'd0);
    check("rst_ill", ill32, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", o_ready32, 1'b1);

    // Back-to-back directed formats with I_ready high.
    i_ready = 1'b1;
    base = log_q.size();
    for (int i = 0; i < ND; i++) send(dir_sel[i], dir_word[i], 5'(i));
    i_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("dir_count", 64'(log_q.size() - base), 64'(ND));
    for (int i = 0; i < ND; i++) begin
      if (base + i < log_q.size()) begin
        check("dir_d32", log_q[base+i].d32, dir_e32[i]);
        check("dir_d64", log_q[base+i].d64, dir_e64[i]);
        check("dir_tag", log_q[base+i].tag, 5'(i));
        check("dir_ill", log_q[base+i].ill, dir_ill[i]);
      end
    end

    // Backpressure: two accepts fill both slots, tag 3 waits at the input.
    i_ready = 1'b0;
    base = log_q.size();
    send(3'd0, 32'h00100093, 5'd1);
    send(3'd0, 32'h00200093, 5'd2);
    i_tag = 5'd3; i_data = 32'h00300093; i_sel = 3'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_ready_low", o_ready32, 1'b0);
      check("bp_hold_tag", tag32, 5'd1);
      check("bp_hold_data", d32, 32'd1);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    send(3'd0, 32'h00300093, 5'd3);
    i_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("bp_count", 64'(log_q.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < log_q.size()) begin
        check("bp_order_tag", log_q[base+i].tag, 5'(i + 1));
        check("bp_order_data", log_q[base+i].d32, 32'(i + 1));
      end
    end

    // Asynchronous reset with both slots full.
    i_ready = 1'b0;
    send(3'd1, 32'hFE20AE23, 5'd4);
    send(3'd2, 32'hFE000EE3, 5'd5);
    i_valid = 1'b0;
    @(negedge clk);
    check("full_valid", o_valid32, 1'b1);
    check("full_ready", o_ready32, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid32", o_valid32, 1'b0);
    check("arst_valid64", o_valid64, 1'b0);
    check("arst_ready", o_ready32, 1'b0);
    check("arst_data", d64, 64'd0);
    check("arst_tag", tag64, 5'd0);
    check("arst_ill", ill64, 1'b0);
    base = log_q.size();
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    #1 check("ready_pre_edge", o_ready32, 1'b0);
    @(posedge clk); #1;
    check("ready_post_edge", o_ready32, 1'b1);
    check("valid_post_edge", o_valid32, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("no_stale", 64'(log_q.size() - base), 64'd0);

    // Random valid/ready traffic; the compare process checks every cycle.
    p0 = n_push; x0 = n_xfer;
    sent = 0; cyc = 0;
    i_valid = 1'b0;
    while (sent < NR && cyc < 60000) begin
      @(negedge clk); acc = i_valid && o_ready32;
      @(posedge clk); #1; cyc++;
      if (acc) sent++;
      i_ready = ($urandom_range(0, 9) < 7);
      if (!i_valid || acc) begin
        i_valid = (sent < NR) && ($urandom_range(0, 9) < 7);
        i_sel   = 3'($urandom_range(0, 7));
        i_data  = $urandom;
        i_tag   = 5'($urandom);
      end
    end
    if (sent < NR) timeout("rand_send");
    i_valid = 1'b0;
    i_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk); #1;
    check("rand_drained", 64'(q.size()), 64'd0);
    check("rand_accepts", 64'(n_push - p0), 64'(NR));
    check("rand_xfers", 64'(n_xfer - x0), 64'(n_push - p0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
